data_mem_responder: RTL

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Bus-slave memory responder: a single-port word memory behind a request/ack
// handshake, with a programmable number of wait states before each ack.
// Optional out-of-range error pulse on err_o when DATA_MEM_RESPONDER_ERR_EN is defined.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o
`ifdef DATA_MEM_RESPONDER_ERR_EN
  ,
  output logic              err_o
`endif
);

  localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [3:0]        r_wait_cnt;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic              r_we;
  logic              r_oor;

  logic              w_req;
  logic [ADDR_W-1:0] w_cur_adr;
  logic              w_cur_we;
  logic              w_cur_oor;
  logic [IDX_W-1:0]  w_cur_idx;
  logic [IDX_W-1:0]  w_wr_idx;
  logic              w_load_dat;
  logic              w_commit;

  logic [DATA_W-1:0] r_mem [DEPTH];

  // In IDLE the request is still on the bus; afterwards only the latched copy counts.
  assign w_req      = (r_state == S_IDLE) && cyc_i && stb_i;
  assign w_cur_adr  = (r_state == S_IDLE) ? adr_i : r_adr;
  assign w_cur_we   = (r_state == S_IDLE) ? we_i  : r_we;
  assign w_cur_oor  = ({1'b0, w_cur_adr} >= DEPTH_L);
  assign w_cur_idx  = w_cur_adr[IDX_W-1:0];
  assign w_wr_idx   = r_adr[IDX_W-1:0];
  assign w_load_dat = (w_state_next == S_ACK) && (r_state != S_ACK) && !w_cur_we;
  assign w_commit   = !rst && (r_state == S_ACK) && r_we && !r_oor;

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path leaves the signal unassigned (no latch).
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_req) w_state_next = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
      S_WAIT: begin
        if (!cyc_i)                w_state_next = S_IDLE;
        else if (r_wait_cnt == 4'd0) w_state_next = S_ACK;
      end
      S_ACK:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    ack_o = 1'b0;
`ifdef DATA_MEM_RESPONDER_ERR_EN
    err_o = 1'b0;
    if (r_state == S_ACK) begin
      ack_o = !r_oor;
      err_o = r_oor;
    end
`else
    if (r_state == S_ACK) ack_o = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= 4'd0;
      r_adr      <= '0;
      r_dat      <= '0;
      r_we       <= 1'b0;
      r_oor      <= 1'b0;
    end else begin
      if (w_req) begin
        r_adr <= adr_i;
        r_dat <= dat_i;
        r_we  <= we_i;
        r_oor <= w_cur_oor;
      end
      if (w_req && (WAIT_CYCLES > 0))
        r_wait_cnt <= WAIT_LOAD;
      else if ((r_state == S_WAIT) && (r_wait_cnt != 4'd0))
        r_wait_cnt <= r_wait_cnt - 4'd1;
    end
  end

  // Read data is captured on the edge entering ACK and then held until the next read.
  always_ff @(posedge clk) begin
    if (rst) begin
      dat_o <= '0;
    end else if (w_load_dat) begin
      if (!w_cur_oor) dat_o <= r_mem[w_cur_idx];
`ifndef DATA_MEM_RESPONDER_ERR_EN
      else            dat_o <= '0;
`endif
    end
  end

  // NOTE: storage has no reset; contents survive rst and map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_wr_idx] <= r_dat;
  end

endmodule
